// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch FSM state encoding
//   NOP_INSTR        : RV32I canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default program counter value after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Next program counter selection (purely combinational).
// Ports:
//   pc, imm, alu_result : current PC, sign-extended immediate, rs1+imm for jalr
//   branch_taken, jal, jalr : control-flow outcome of the current instruction
//   next_pc   : selected target (may be misaligned; the caller decides what to do)
//   pc_plus4  : sequential successor / link address
// Priority: jalr > jal > branch_taken > sequential. All adds wrap modulo 2^32.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_rel;

  assign pc_rel   = pc + imm;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jalr) begin
      // jalr clears bit 0 of the computed target
      next_pc = alu_result & ~32'd1;
    end else if (jal || branch_taken) begin
      next_pc = pc_rel;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage of the RV32I core.
// Owns the PC, fetches one instruction word per instruction over a
// ready-handshaked memory port, holds it for the decoder and advances the PC
// once the downstream stage acknowledges execution.
// Ports:
//   clk, reset (async, active-low)
//   imem_req / imem_addr / imem_ready / imem_rdata : instruction memory port
//   instrCode / instr_valid : held instruction for the decoder (NOP when idle)
//   pc / pc_plus4           : current instruction address and its successor
//   instr_ack, branch_taken, jal, jalr, imm, alu_result : execution outcome
//   misalign_err            : sticky misaligned-target flag
// Build option: FETCH_ALIGN_CHECK_EN enables misaligned-target trapping
// (S_TRAP, left only by reset). Without it targets are forced word-aligned
// and misalign_err is tied low.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrCode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        misalign_err
);

  fetch_state_e state, state_nx;
  logic [31:0]  instr_reg;
  logic [31:0]  raw_next_pc;
  logic [31:0]  pc_target;
  logic         retire;

  next_pc_sel u_next_pc_sel (
    .pc           (pc),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .next_pc      (raw_next_pc),
    .pc_plus4     (pc_plus4)
  );

  // Control-flow inputs only matter when the current instruction retires
  assign retire = (state == S_EXEC) && instr_ack;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |raw_next_pc[1:0];
  // A misaligned target is recorded as-is so it can be inspected in S_TRAP
  assign pc_target  = raw_next_pc;
`else
  assign pc_target  = raw_next_pc & ~32'd3;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RESET;
      pc        <= RESET_PC;
      instr_reg <= NOP_INSTR;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && imem_ready) begin
        instr_reg <= imem_rdata;
      end
      if (retire) begin
        pc <= pc_target;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_nx = misaligned ? S_TRAP : S_FETCH;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_RESET;
    endcase
  end

  assign imem_addr = pc;
  assign instrCode = instr_valid ? instr_reg : NOP_INSTR;

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
    end else if (retire && misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected fetch
// addresses and instruction words; a negedge monitor pops and compares
// whenever the DUT accepts a fetch or retires an instruction.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'h1357_9BD0;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrCode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        misalign_err;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instrCode    (instrCode),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_ack    (instr_ack),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .alu_result   (alu_result),
    .misalign_err (misalign_err)
  );

  // Memory model: each word is its address scrambled by a fixed key
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(addr ^ KEY);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req && imem_ready) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL fetch_unexpected: got addr %h required none", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (instr_valid && instr_ack) begin
        if (exp_instr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL retire_unexpected: got instr %h required none", instrCode);
        end else begin
          chk("instr_code", instrCode, exp_instr_q.pop_front());
        end
      end
    end
  end

  // One instruction starting from S_FETCH at posedge+1: rdly stall cycles
  // (with a stray ack that must be ignored), then adly exec wait cycles
  // (with a stray ready that must be ignored), then ack with given controls.
  task automatic run_instr(input int rdly, input int adly,
                           input logic br, input logic j, input logic jr,
                           input logic [31:0] im, input logic [31:0] alu,
                           input logic [31:0] nxt);
    expect_fetch(mpc);
    repeat (rdly) begin
      instr_ack = 1'b1; jal = 1'b1; imm = 32'h40;
      @(negedge clk);
      chk("stall_addr", imem_addr, mpc);
      chk("stall_valid", {31'b0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    instr_ack = 1'b0; jal = 1'b0; imm = 32'd0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    repeat (adly) begin
      imem_ready = 1'b1;
      @(negedge clk);
      chk("exec_valid", {31'b0, instr_valid}, 32'd1);
      chk("exec_pc", pc, mpc);
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    branch_taken = br; jal = j; jalr = jr; imm = im; alu_result = alu;
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'd0; alu_result = 32'd0;
    mpc = nxt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0;
    branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm = 32'd0; alu_result = 32'd0;
    mpc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instrCode, 32'h0000_0013);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);

    // Back-to-back: ready and ack held high, one instruction per 2 cycles
    reset = 1'b1; imem_ready = 1'b1; instr_ack = 1'b1;
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    repeat (7) @(posedge clk);
    #1;
    imem_ready = 1'b0; instr_ack = 1'b0;
    chk("b2b_pc", pc, 32'hC);
    chk("b2b_req", {31'b0, imem_req}, 32'd1);
    mpc = 32'hC;

    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_00F4, 32'h0, 32'h100);
    run_instr(0, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0F0);
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h100);
    run_instr(0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h201, 32'h200);
    run_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    run_instr(3, 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    expect_fetch(32'h0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0; jal = 1'b1; imm = 32'h2; instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0; jal = 1'b0; imm = 32'd0; imem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("trap_err", {31'b0, misalign_err}, 32'd1);
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      chk("trap_valid", {31'b0, instr_valid}, 32'd0);
      chk("trap_pc", pc, 32'h2);
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    mpc = 32'h0;
`else
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h0, 32'h0);
    chk("noalign_err", {31'b0, misalign_err}, 32'd0);
`endif
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

    // Reset during S_EXEC with ack high: abort, no PC update
    exp_addr_q.push_back(mpc);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0; instr_ack = 1'b1; jal = 1'b1; imm = 32'h40;
    #2; reset = 1'b0; #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_instr", instrCode, 32'h0000_0013);
    chk("abort_valid", {31'b0, instr_valid}, 32'd0);
    chk("abort_req", {31'b0, imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_pc", pc, 32'h0);
    instr_ack = 1'b0; jal = 1'b0; imm = 32'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    mpc = 32'h0;
    run_instr(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
    @(negedge clk);
    chk("final_pc", pc, 32'h4);
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("instr_q_empty", exp_instr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
